// File: rtl/tone_direction_decoder.sv
// Tone direction decoder: synchronises and debounces the five band-pass tone
// detector outputs and turns a single, stable direction tone into a held
// junction command (tdEn/tdDir) for the drive FSM.
// Optional diagnostics (tdCmdCount, tdConflict, tdTimeout) are built when the
// macro TONE_DIAG_EN is defined; core behaviour does not depend on it.
module tone_direction_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned HOLD_CYCLES     = 2_500_000,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tdAck,
`ifdef TONE_DIAG_EN
  output logic [7:0] tdCmdCount,
  output logic       tdConflict,
  output logic       tdTimeout,
`endif
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdBusy
);

  localparam int unsigned CntW = 26;
  localparam logic [CntW-1:0] DebMax   = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StQualify, StPresent, StRelease} state_e;

  state_e          state_q, state_d;
  logic [4:0]      bp_raw;
  logic [4:0]      sync1_q, sync2_q;
  logic [CntW-1:0] deb_cnt_q [5];
  logic [4:0]      valid;
  logic [1:0]      cand, cand_q, dir_q;
  logic            single, conflict, cancel, any_valid;
  logic [CntW-1:0] hold_cnt_q, tout_cnt_q;

  // bit 4 is the cancel tone, bits 3:0 map directly to direction codes
  assign bp_raw = {bp5, bp4, bp3, bp2, bp1};

  // Two-flop synchronisers for the asynchronous tone inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bp_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce counters: count while high, saturate, clear on low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!sync2_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] != DebMax) begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 26'd1;
        end
      end
    end
  end

  // Valid drops in the very cycle the synced input goes low
  always_comb begin
    for (int i = 0; i < 5; i++) valid[i] = sync2_q[i] && (deb_cnt_q[i] == DebMax);
  end

  // Candidate decode from the four direction channels
  always_comb begin
    cand     = 2'b00;
    single   = 1'b0;
    conflict = 1'b0;
    unique case (valid[3:0])
      4'b0000: ;
      4'b0001: begin cand = 2'b00; single = 1'b1; end
      4'b0010: begin cand = 2'b01; single = 1'b1; end
      4'b0100: begin cand = 2'b10; single = 1'b1; end
      4'b1000: begin cand = 2'b11; single = 1'b1; end
      default: conflict = 1'b1;
    endcase
  end

  assign cancel    = valid[4];
  assign any_valid = |valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (single && !cancel) state_d = StQualify;
      end
      StQualify: begin
        if (!single || cancel || (cand != cand_q)) state_d = StIdle;
        else if (hold_cnt_q == HoldLast)           state_d = StPresent;
      end
      StPresent: begin
        // ack and timeout together resolve the same way, so no priority needed
        if (tdAck || cancel || (tout_cnt_q == TimeLast)) state_d = StRelease;
      end
      StRelease: begin
        if (!any_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Hold/timeout counters, candidate latch and frozen output direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      tout_cnt_q <= '0;
      cand_q     <= 2'b00;
      dir_q      <= 2'b00;
    end else begin
      hold_cnt_q <= (state_q == StQualify && state_d == StQualify) ? hold_cnt_q + 26'd1 : '0;
      tout_cnt_q <= (state_q == StPresent && state_d == StPresent) ? tout_cnt_q + 26'd1 : '0;
      if (state_q == StIdle && state_d == StQualify)     cand_q <= cand;
      if (state_q == StQualify && state_d == StPresent)  dir_q  <= cand_q;
    end
  end

  // FSM outputs
  always_comb begin
    tdEn   = (state_q == StPresent);
    tdBusy = (state_q != StIdle);
    tdDir  = dir_q;
  end

`ifdef TONE_DIAG_EN
  logic timeout_exit;
  assign timeout_exit = (state_q == StPresent) && !tdAck && !cancel && (tout_cnt_q == TimeLast);

  // Diagnostic command counter, sticky conflict flag and timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdCmdCount <= 8'd0;
      tdConflict <= 1'b0;
      tdTimeout  <= 1'b0;
    end else begin
      if (state_q == StQualify && state_d == StPresent) tdCmdCount <= tdCmdCount + 8'd1;
      if (conflict && (state_q == StIdle || state_q == StQualify)) tdConflict <= 1'b1;
      tdTimeout <= timeout_exit;
    end
  end
`endif

endmodule

// File: tb/tb_tone_direction_decoder.sv
// Bench for tone_direction_decoder: directed scenarios plus random tone traffic,
// checked by an edge scoreboard fed from a timestamp-based reference model.
module tb_tone_direction_decoder;

  localparam int unsigned D = 4;
  localparam int unsigned H = 8;
  localparam int unsigned T = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bp1 = 1'b0, bp2 = 1'b0, bp3 = 1'b0, bp4 = 1'b0, bp5 = 1'b0;
  logic       tdAck = 1'b0;
  logic       tdEn, tdBusy;
  logic [1:0] tdDir;
`ifdef TONE_DIAG_EN
  logic [7:0] tdCmdCount;
  logic       tdConflict, tdTimeout;
  int         dut_timeouts = 0;
`endif

  always #5 clk = ~clk;

  tone_direction_decoder #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bp1       (bp1),
    .bp2       (bp2),
    .bp3       (bp3),
    .bp4       (bp4),
    .bp5       (bp5),
    .tdAck     (tdAck),
`ifdef TONE_DIAG_EN
    .tdCmdCount(tdCmdCount),
    .tdConflict(tdConflict),
    .tdTimeout (tdTimeout),
`endif
    .tdEn      (tdEn),
    .tdDir     (tdDir),
    .tdBusy    (tdBusy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected output edges, stamped with the clock edge after which they appear
  typedef struct {
    int at;
    int lvl;
    int dir;
  } ev_t;
  ev_t en_q[$];
  ev_t busy_q[$];

  // Reference model: tone run lengths in samples, command timing from timestamps
  int run_cur[5], run_prev[5];
  int phase;      // 0 quiet, 1 qualifying, 2 command shown, 3 waiting for silence
  int q_start, q_dir, issue_at, shown_dir;
  int m_cmds, m_timeouts, m_conflict;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      run_cur[i]  = 0;
      run_prev[i] = 0;
    end
    phase = 0; q_start = 0; q_dir = 0; issue_at = 0; shown_dir = 0;
    m_cmds = 0; m_timeouts = 0; m_conflict = 0;
    en_q.delete();
    busy_q.delete();
  endfunction

  always @(posedge clk) begin
    bit   v[5];
    int   nv, one, old_phase;
    logic [4:0] bpv;
    ev_t  e;
    cyc = cyc + 1;
    bpv = {bp5, bp4, bp3, bp2, bp1};
    if (!rst_n) begin
      model_reset();
    end else begin
      // a tone is valid once it has been sampled high D+1 times in a row,
      // seen through the two-stage synchroniser
      for (int i = 0; i < 5; i++) v[i] = (run_prev[i] >= int'(D) + 1);
      nv = 0; one = -1;
      for (int i = 0; i < 4; i++) if (v[i]) begin nv++; one = i; end
      old_phase = phase;
      if ((phase == 0 || phase == 1) && nv > 1) m_conflict = 1;
      case (phase)
        0: if (nv == 1 && !v[4]) begin phase = 1; q_start = cyc; q_dir = one; end
        1: begin
          if (nv != 1 || v[4] || one != q_dir) phase = 0;
          else if (cyc - q_start == int'(H)) begin
            phase = 2; issue_at = cyc; shown_dir = q_dir; m_cmds++;
          end
        end
        2: if (tdAck || v[4] || cyc - issue_at == int'(T)) begin
          phase = 3;
          if (!tdAck && !v[4]) m_timeouts++;
        end
        default: if (nv == 0 && !v[4]) phase = 0;
      endcase
      if ((old_phase == 2) != (phase == 2)) begin
        e.at = cyc; e.lvl = (phase == 2) ? 1 : 0; e.dir = shown_dir;
        en_q.push_back(e);
      end
      if ((old_phase != 0) != (phase != 0)) begin
        e.at = cyc; e.lvl = (phase != 0) ? 1 : 0; e.dir = 0;
        busy_q.push_back(e);
      end
      for (int i = 0; i < 5; i++) begin
        run_prev[i] = run_cur[i];
        run_cur[i]  = bpv[i] ? run_cur[i] + 1 : 0;
      end
    end
  end

  // Monitor: every DUT output edge must match the next expected edge
  logic prev_en = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (tdEn !== prev_en) begin
        if (en_q.size() == 0) begin
          chk("tdEn_unexpected_edge", int'(tdEn), int'(prev_en));
        end else begin
          e = en_q.pop_front();
          chk("tdEn_edge_cycle", cyc, e.at);
          chk("tdEn_edge_level", int'(tdEn), e.lvl);
          chk("tdDir_at_edge", int'(tdDir), e.dir);
        end
        prev_en = tdEn;
      end
      if (tdBusy !== prev_busy) begin
        if (busy_q.size() == 0) begin
          chk("tdBusy_unexpected_edge", int'(tdBusy), int'(prev_busy));
        end else begin
          e = busy_q.pop_front();
          chk("tdBusy_edge_cycle", cyc, e.at);
          chk("tdBusy_edge_level", int'(tdBusy), e.lvl);
        end
        prev_busy = tdBusy;
      end
`ifdef TONE_DIAG_EN
      if (tdTimeout === 1'b1) dut_timeouts++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    {bp5, bp4, bp3, bp2, bp1} = 5'b0;
    tdAck = 1'b0;
    repeat (n) tick();
  endtask

  // Reset pulse placed between clock edges
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tdEn", int'(tdEn), 0);
    chk("async_reset_tdBusy", int'(tdBusy), 0);
    chk("async_reset_tdDir", int'(tdDir), 0);
`ifdef TONE_DIAG_EN
    chk("async_reset_cmdcount", int'(tdCmdCount), 0);
    dut_timeouts = 0;
`endif
    model_reset();
    prev_en   = 1'b0;
    prev_busy = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int len, pick;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tdEn", int'(tdEn), 0);
    chk("reset_tdDir", int'(tdDir), 0);
    chk("reset_tdBusy", int'(tdBusy), 0);
`ifdef TONE_DIAG_EN
    chk("reset_cmdcount", int'(tdCmdCount), 0);
    chk("reset_conflict", int'(tdConflict), 0);
`endif
    rst_n = 1'b1;
    idle(5);

    // 1: LEFT tone, ack on the third command cycle, no re-trigger
    bp2 = 1'b1;
    repeat (17) tick();
    tdAck = 1'b1;
    tick();
    tdAck = 1'b0;
    repeat (22) tick();
    idle(20);

    // 2: two direction tones together
    bp1 = 1'b1; bp3 = 1'b1;
    repeat (30) tick();
    idle(10);
`ifdef TONE_DIAG_EN
    chk("diag_conflict_sticky", int'(tdConflict), m_conflict);
`endif

    // 3: glitchy BACK tone
    for (int r = 0; r < 10; r++) begin
      bp4 = 1'b1; repeat (3) tick();
      bp4 = 1'b0; tick();
    end
    idle(10);

    // 4: RIGHT tone, never acknowledged
    bp3 = 1'b1;
    repeat (60) tick();
    idle(20);

    // 5: STRAIGHT command cancelled by bp5
    bp1 = 1'b1;
    repeat (20) tick();
    bp5 = 1'b1;
    repeat (6) tick();
    bp1 = 1'b0;
    repeat (3) tick();
    bp5 = 1'b0;
    idle(20);

    // 6: reset mid-command, tone persists afterwards
    bp2 = 1'b1;
    repeat (20) tick();
    pulse_reset();
    repeat (40) tick();
    idle(50);

    // Random tone traffic with random acks
    for (int s = 0; s < 80; s++) begin
      len  = $urandom_range(1, 50);
      pick = $urandom_range(0, 9);
      {bp5, bp4, bp3, bp2, bp1} = 5'b0;
      if (pick < 6) begin
        case ($urandom_range(0, 3))
          0: bp1 = 1'b1;
          1: bp2 = 1'b1;
          2: bp3 = 1'b1;
          default: bp4 = 1'b1;
        endcase
      end else if (pick == 6) begin
        bp5 = 1'b1;
        bp2 = $urandom_range(0, 1) == 1;
      end else if (pick == 7) begin
        bp1 = 1'b1; bp4 = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        tdAck = ($urandom_range(0, 7) == 0);
        tick();
      end
      tdAck = 1'b0;
    end
    idle(60);

    chk("tdEn_events_outstanding", en_q.size(), 0);
    chk("tdBusy_events_outstanding", busy_q.size(), 0);
    chk("final_idle_tdBusy", int'(tdBusy), 0);
`ifdef TONE_DIAG_EN
    chk("diag_cmdcount", int'(tdCmdCount), m_cmds % 256);
    chk("diag_timeout_pulses", dut_timeouts, m_timeouts);
    chk("diag_conflict_final", int'(tdConflict), m_conflict);
`endif
    $display("info: model saw %0d commands, %0d timeouts, conflict=%0d since last reset",
             m_cmds, m_timeouts, m_conflict);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
